// File: rtl/qbert_jump_ctrl_if.sv
// qbert_jump_ctrl_if
//   Groups the signals for two things:
//     - the command handshake from the NIOS/MIWI side
//     - the jump interface towards the sprite block
//   master : command source / sprite side
//            (drives cmd_valid, cmd_dir, qbert_x, qbert_y)
//   slave  : jump controller
//            (drives cmd_ready, x0, y0, x1, y1, qbert_jump)
interface qbert_jump_ctrl_if;
   logic        cmd_valid;
   logic [1:0]  cmd_dir;
   logic        cmd_ready;
   logic [10:0] qbert_x;
   logic [9:0]  qbert_y;
   logic [10:0] x0;
   logic [9:0]  y0;
   logic [10:0] x1;
   logic [9:0]  y1;
   logic        qbert_jump;

   modport master (
      output cmd_valid, cmd_dir, qbert_x, qbert_y,
      input  cmd_ready, x0, y0, x1, y1, qbert_jump
   );

   modport slave (
      input  cmd_valid, cmd_dir, qbert_x, qbert_y,
      output cmd_ready, x0, y0, x1, y1, qbert_jump
   );
endinterface

// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl
//   Issues Q*bert jump commands to the sprite block.
//   Tracks the current pyramid cell (row, col).
//   Waits for the sprite to report arrival at the target before the next jump.
//
// Ports
//   clk     : system clock
//   reset   : synchronous, active-low reset
//   bus     : qbert_jump_ctrl_if.slave
//               cmd_valid/cmd_dir/cmd_ready : command handshake
//               qbert_x/qbert_y             : sprite position
//               x0,y0,x1,y1,qbert_jump      : jump start, target and start pulse
//   row,col : current cell
//   done    : one-cycle pulse on landing
//   fall    : one-cycle pulse when a command would leave the pyramid
//   timeout : one-cycle pulse, together with done, when a jump is aborted
//
// Optional feature
//   QBERT_JUMP_TIMEOUT_EN
//     Defined: a FLY watchdog forces LAND after TIMEOUT cycles.
//     Undefined: FLY waits for arrival and timeout is tied low.
module qbert_jump_ctrl #(
   parameter logic [10:0] X_ORG   = 11'd100,
   parameter logic [9:0]  Y_ORG   = 10'd240,
   parameter logic [10:0] XDIAG   = 11'd60,
   parameter logic [9:0]  YDIAG   = 10'd60,
   parameter int unsigned ROWS    = 7,
   parameter logic [31:0] TIMEOUT = 32'd200_000_000
) (
   input  logic                clk,
   input  logic                reset,
   qbert_jump_ctrl_if.slave    bus,
   output logic [2:0]          row,
   output logic [2:0]          col,
   output logic                done,
   output logic                fall,
   output logic                timeout
);

   typedef enum logic [2:0] {IDLE, LAUNCH, FLY, LAND, FALL} state_t;

   localparam logic signed [3:0] MAX_ROW = 4'(ROWS - 1);
   localparam logic [9:0]        YHALF   = YDIAG >> 1;

   state_t            state, state_n;
   logic [2:0]        trow, tcol;
   logic signed [3:0] nr, nc, dr, dc;
   logic              legal;
   logic              accept;
   logic              to_hit;
   logic [10:0]       tx;
   logic [9:0]        ty;

   // Cell to screen coordinates, evaluated modulo 2^12 and then truncated.
   function automatic logic [10:0] cell_x(input logic [2:0] r);
      logic [11:0] t;
      t = {1'b0, X_ORG} + {9'd0, r} * {1'b0, XDIAG};
      return t[10:0];
   endfunction

   function automatic logic [9:0] cell_y(input logic [2:0] r, input logic [2:0] c);
      logic [11:0] t;
      t = {2'b0, Y_ORG} + {9'd0, c} * {2'b0, YDIAG} - {9'd0, r} * {2'b0, YHALF};
      return t[9:0];
   endfunction

   // Candidate target cell for the presented direction.
   always_comb begin
      dr = bus.cmd_dir[1] ? 4'sd1 : -4'sd1;
      case (bus.cmd_dir)
         2'b00:   dc = -4'sd1;
         2'b11:   dc = 4'sd1;
         default: dc = 4'sd0;
      endcase
      nr    = $signed({1'b0, row}) + dr;
      nc    = $signed({1'b0, col}) + dc;
      legal = (nc >= 4'sd0) && (nc <= nr) && (nr <= MAX_ROW);
      tx    = cell_x(nr[2:0]);
      ty    = cell_y(nr[2:0], nc[2:0]);
   end

`ifdef QBERT_JUMP_TIMEOUT_EN
   logic [31:0] fly_cnt;
   logic        fly_expired;
   assign fly_expired = (fly_cnt == TIMEOUT - 32'd1);
`else
   logic unused_timeout_param;
   assign unused_timeout_param = ^TIMEOUT;
`endif

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      to_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               accept  = 1'b1;
               state_n = legal ? LAUNCH : FALL;
            end
         end
         LAUNCH: state_n = FLY;
         FLY: begin
            if (bus.qbert_x == bus.x1 && bus.qbert_y == bus.y1) begin
               state_n = LAND;
            end
`ifdef QBERT_JUMP_TIMEOUT_EN
            else if (fly_expired) begin
               state_n = LAND;
               to_hit  = 1'b1;
            end
`endif
         end
         LAND:    state_n = IDLE;
         FALL:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Pulse outputs and cell/coordinate updates are keyed on state_n.
   // This makes them registered yet visible during the state they belong to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         row            <= '0;
         col            <= '0;
         trow           <= '0;
         tcol           <= '0;
         bus.x0         <= X_ORG;
         bus.x1         <= X_ORG;
         bus.y0         <= Y_ORG;
         bus.y1         <= Y_ORG;
         bus.cmd_ready  <= 1'b1;
         bus.qbert_jump <= 1'b0;
         done           <= 1'b0;
         fall           <= 1'b0;
      end else begin
         state          <= state_n;
         bus.cmd_ready  <= (state_n == IDLE);
         bus.qbert_jump <= (state_n == LAUNCH);
         done           <= (state_n == LAND);
         fall           <= (state_n == FALL);
         if (accept && legal) begin
            trow   <= nr[2:0];
            tcol   <= nc[2:0];
            bus.x1 <= tx;
            bus.y1 <= ty;
         end
         if (state == FLY && state_n == LAND) begin
            row    <= trow;
            col    <= tcol;
            bus.x0 <= bus.x1;
            bus.y0 <= bus.y1;
         end
         if (state_n == FALL) begin
            row    <= '0;
            col    <= '0;
            bus.x0 <= X_ORG;
            bus.x1 <= X_ORG;
            bus.y0 <= Y_ORG;
            bus.y1 <= Y_ORG;
         end
      end
   end

`ifdef QBERT_JUMP_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         fly_cnt <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= to_hit;
         if (state == LAUNCH) begin
            fly_cnt <= '0;
         end else if (state == FLY) begin
            fly_cnt <= fly_cnt + 32'd1;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
module tb_qbert_jump_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] row, col;
   logic       done, fall, timeout;
   int         n_pass = 0;
   int         n_total = 0;
   int         mr = 0;
   int         mc = 0;

   qbert_jump_ctrl_if bus ();

   qbert_jump_ctrl #(.TIMEOUT(32'd16)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .row     (row),
      .col     (col),
      .done    (done),
      .fall    (fall),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ref_x(input int r);
      return 11'(100 + 60 * r);
   endfunction

   function automatic logic [9:0] ref_y(input int r, input int c);
      return 10'(240 + 60 * c - 30 * r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One command through the full handshake, checked against the (mr, mc) model.
   // If hold is set, cmd_valid stays high after acceptance.
   task automatic do_cmd(input logic [1:0] dir, input int delay, input bit hold);
      int nr, nc;
      bit ok;
      nr = mr + (dir[1] ? 1 : -1);
      nc = mc + ((dir == 2'b11) ? 1 : (dir == 2'b00) ? -1 : 0);
      ok = (nc >= 0) && (nc <= nr) && (nr <= 6);
      n_total++;
      if (bus.cmd_ready !== 1'b1) begin
         $display("FAIL idle_ready: got %b expected 1", bus.cmd_ready);
      end else n_pass++;
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = dir;
      step();
      if (!hold) bus.cmd_valid = 1'b0;
      if (!ok) begin
         n_total++;
         if ({fall, bus.qbert_jump, row, col, bus.x0, bus.x1, bus.y0, bus.y1} !==
             {1'b1, 1'b0, 3'd0, 3'd0, 11'd100, 11'd100, 10'd240, 10'd240}) begin
            $display("FAIL fall_cycle: got fall=%b jump=%b rc=%0d,%0d x0=%0d x1=%0d y0=%0d y1=%0d expected fall=1 jump=0 rc=0,0 x=100 y=240",
                     fall, bus.qbert_jump, row, col, bus.x0, bus.x1, bus.y0, bus.y1);
         end else n_pass++;
         mr = 0;
         mc = 0;
         bus.qbert_x = 11'd100;
         bus.qbert_y = 10'd240;
         step();
         n_total++;
         if ({bus.cmd_ready, fall, bus.qbert_jump} !== 3'b100) begin
            $display("FAIL fall_after: got ready/fall/jump=%b expected 100",
                     {bus.cmd_ready, fall, bus.qbert_jump});
         end else n_pass++;
         return;
      end
      // LAUNCH cycle
      n_total++;
      if ({bus.qbert_jump, bus.cmd_ready, bus.x1, bus.y1, bus.x0, bus.y0} !==
          {1'b1, 1'b0, ref_x(nr), ref_y(nr, nc), ref_x(mr), ref_y(mr, mc)}) begin
         $display("FAIL launch: got jump=%b ready=%b x1=%0d y1=%0d x0=%0d y0=%0d expected jump=1 ready=0 x1=%0d y1=%0d x0=%0d y0=%0d",
                  bus.qbert_jump, bus.cmd_ready, bus.x1, bus.y1, bus.x0, bus.y0,
                  ref_x(nr), ref_y(nr, nc), ref_x(mr), ref_y(mr, mc));
      end else n_pass++;
      step();
      // FLY cycles; sprite arrives after 'delay' cycles
      for (int i = 0; i < delay; i++) begin
         n_total++;
         if ({bus.qbert_jump, bus.cmd_ready, done} !== 3'b000) begin
            $display("FAIL fly: got jump/ready/done=%b expected 000",
                     {bus.qbert_jump, bus.cmd_ready, done});
         end else n_pass++;
         step();
      end
      bus.qbert_x = ref_x(nr);
      bus.qbert_y = ref_y(nr, nc);
      n_total++;
      if ({bus.qbert_jump, bus.cmd_ready, done} !== 3'b000) begin
         $display("FAIL fly_last: got jump/ready/done=%b expected 000",
                  {bus.qbert_jump, bus.cmd_ready, done});
      end else n_pass++;
      step();
      mr = nr;
      mc = nc;
      n_total++;
      if ({done, timeout, bus.cmd_ready, bus.qbert_jump, row, col, bus.x0, bus.y0} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 3'(mr), 3'(mc), ref_x(mr), ref_y(mr, mc)}) begin
         $display("FAIL land: got done=%b to=%b ready=%b rc=%0d,%0d x0=%0d y0=%0d expected done=1 to=0 ready=0 rc=%0d,%0d x0=%0d y0=%0d",
                  done, timeout, bus.cmd_ready, row, col, bus.x0, bus.y0,
                  mr, mc, ref_x(mr), ref_y(mr, mc));
      end else n_pass++;
      step();
      n_total++;
      if ({bus.cmd_ready, done, bus.qbert_jump} !== 3'b100) begin
         $display("FAIL post_land: got ready/done/jump=%b expected 100",
                  {bus.cmd_ready, done, bus.qbert_jump});
      end else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      mr = 0;
      mc = 0;
      n_total++;
      if ({bus.cmd_ready, bus.qbert_jump, done, fall, timeout, row, col,
           bus.x0, bus.x1, bus.y0, bus.y1} !==
          {5'b10000, 3'd0, 3'd0, 11'd100, 11'd100, 10'd240, 10'd240}) begin
         $display("FAIL reset: got ready=%b jump=%b done=%b fall=%b to=%b rc=%0d,%0d x0=%0d x1=%0d y0=%0d y1=%0d",
                  bus.cmd_ready, bus.qbert_jump, done, fall, timeout, row, col,
                  bus.x0, bus.x1, bus.y0, bus.y1);
      end else n_pass++;
   endtask

   task automatic test_first_jump();
      do_cmd(2'b11, 0, 1'b0);
   endtask

   task automatic test_fall_top();
      test_reset();
      do_cmd(2'b00, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      test_reset();
      do_cmd(2'b11, 1, 1'b0);
      // Held command during FLY/LAND is only taken after returning to IDLE.
      do_cmd(2'b10, 3, 1'b1);
      do_cmd(2'b10, 0, 1'b0);
   endtask

   task automatic test_fall_bottom();
      test_reset();
      for (int i = 0; i < 6; i++) do_cmd(2'b10, 0, 1'b0);
      n_total++;
      if (row !== 3'd6) begin
         $display("FAIL bottom_row: got %0d expected 6", row);
      end else n_pass++;
      do_cmd(2'b11, 0, 1'b0);
   endtask

   task automatic test_reset_mid_fly();
      test_reset();
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = 2'b11;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      n_total++;
      if ({bus.cmd_ready, bus.qbert_jump, done, row, col, bus.x1, bus.y1} !==
          {3'b100, 3'd0, 3'd0, 11'd100, 10'd240}) begin
         $display("FAIL reset_fly: got ready=%b jump=%b done=%b rc=%0d,%0d x1=%0d y1=%0d expected 1 0 0 0,0 100 240",
                  bus.cmd_ready, bus.qbert_jump, done, row, col, bus.x1, bus.y1);
      end else n_pass++;
      reset = 1'b1;
      mr = 0;
      mc = 0;
   endtask

   task automatic test_random();
      test_reset();
      for (int i = 0; i < 40; i++) begin
         do_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);
      end
   endtask

`ifdef QBERT_JUMP_TIMEOUT_EN
   task automatic test_timeout();
      test_reset();
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = 2'b10;
      step();
      bus.cmd_valid = 1'b0;
      n_total++;
      if (bus.qbert_jump !== 1'b1) begin
         $display("FAIL to_launch: got %b expected 1", bus.qbert_jump);
      end else n_pass++;
      for (int i = 0; i < 16; i++) begin
         step();
         n_total++;
         if ({done, timeout} !== 2'b00) begin
            $display("FAIL to_fly: cycle %0d got done/to=%b expected 00", i, {done, timeout});
         end else n_pass++;
      end
      step();
      n_total++;
      if ({done, timeout, row, col} !== {2'b11, 3'd1, 3'd0}) begin
         $display("FAIL to_land: got done=%b to=%b rc=%0d,%0d expected 1 1 1,0",
                  done, timeout, row, col);
      end else n_pass++;
      mr = 1;
      mc = 0;
      bus.qbert_x = ref_x(1);
      bus.qbert_y = ref_y(1, 0);
      step();
   endtask
`endif

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = 2'b00;
      bus.qbert_x   = 11'd100;
      bus.qbert_y   = 10'd240;
      test_reset();
      test_first_jump();
      test_fall_top();
      test_back_to_back();
      test_fall_bottom();
      test_reset_mid_fly();
      test_random();
`ifdef QBERT_JUMP_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
endmodule
